// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between two byte sources,
// with a completion watchdog and a sticky timeout flag.
module uart_tx_arbiter #(
  parameter int TIMEOUT = 200000,
  parameter int TO_W    = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_a,
  input  logic [7:0] data_a,
  output logic       ack_a,
  input  logic       req_b,
  input  logic [7:0] data_b,
  output logic       ack_b,
  output logic       tx_load,
  output logic [7:0] tx_data,
  input  logic       tx_done,
  output logic       busy,
  output logic       grant_id,
  output logic       timeout_err,
  input  logic       err_clr
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    ACK
  } state_t;

  localparam logic [TO_W-1:0] TLAST = TO_W'(TIMEOUT - 1);

  state_t          state;
  logic            rr_last;
  logic [TO_W-1:0] timer;
  logic            win_b;
  logic            to_evt;

  // B wins when alone, or on a tie when A held the last grant
  assign win_b  = req_b & (~req_a | ~rr_last);
  assign to_evt = (state == WAIT) & ~tx_done & (timer == TLAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rr_last     <= 1'b1;
      timer       <= '0;
      tx_load     <= 1'b0;
      tx_data     <= 8'h00;
      ack_a       <= 1'b0;
      ack_b       <= 1'b0;
      busy        <= 1'b0;
      grant_id    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      tx_load <= 1'b0;
      ack_a   <= 1'b0;
      ack_b   <= 1'b0;

      if (to_evt)
        timeout_err <= 1'b1;
      else if (err_clr)
        timeout_err <= 1'b0;

      unique case (state)
        IDLE: begin
          if (req_a | req_b) begin
            grant_id <= win_b;
            tx_data  <= win_b ? data_b : data_a;
            tx_load  <= 1'b1;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          timer <= timer + TO_W'(1);
          if (tx_done | to_evt) begin
            rr_last <= grant_id;
            ack_a   <= ~grant_id;
            ack_b   <= grant_id;
            state   <= ACK;
          end
        end
        ACK: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
